// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch (F)
// and load/store (D), with a D-held lock for atomic read-modify-write sequences.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic              f_we,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [DATA_W-1:0] f_wdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              f_gnt,
    output logic              d_gnt,
    output logic              f_rvalid,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    logic prio_q, prio_d;
    logic lock_q, lock_d;
    logic f_rvalid_q, f_rvalid_d;
    logic d_rvalid_q, d_rvalid_d;
    logic f_win, d_win;

    // Grant selection and next-state; reset suppresses every grant.
    always_comb begin
        f_win      = 1'b0;
        d_win      = 1'b0;
        prio_d     = prio_q;
        lock_d     = lock_q;
        f_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;

        if (!rst) begin
            if (lock_q) begin
                d_win = d_req;
            end else if (f_req && d_req) begin
                f_win = ~prio_q;
                d_win = prio_q;
            end else begin
                f_win = f_req;
                d_win = d_req;
            end
        end

        if (f_win) begin
            prio_d = 1'b1;
        end
        if (d_win) begin
            prio_d = 1'b0;
            lock_d = d_lock;
        end

        f_rvalid_d = f_win & ~f_we;
        d_rvalid_d = d_win & ~d_we;
    end

    assign f_gnt       = f_win;
    assign d_gnt       = d_win;
    assign ram_wr_en   = d_win ? d_we : (f_win & f_we);
    assign ram_address = d_win ? d_addr : f_addr;
    assign ram_data_in = d_win ? d_wdata : f_wdata;
    assign rdata       = ram_data_out;

    // A read granted just before reset must not surface while reset is high.
    assign f_rvalid = f_rvalid_q & ~rst;
    assign d_rvalid = d_rvalid_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            f_rvalid_q <= f_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port, 1024×32 program/data RAM between the CPU instruction-fetch unit (port F) and the load/store unit (port D). It sits directly in front of the RAM and drives its `wr_en`/`address`/`data_in`. It returns read data with a per-port valid strobe. Fairness is round-robin, and port D can hold a lock for atomic read-modify-write sequences.

## Interface
Parameters:
- `ADDR_W`, 10, RAM address width (1024 words).
- `DATA_W`, 32, RAM data width.

Ports (F = fetch, D = data):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `f_req`, `d_req`  in  1  access request, held until granted.
- `f_we`, `d_we`  in  1  1 = write, 0 = read; valid with req.
- `f_addr`, `d_addr`  in  ADDR_W  word address.
- `f_wdata`, `d_wdata`  in  DATA_W  write data.
- `d_lock`  in  1  with a granted D request, keeps the RAM reserved for D afterwards.
- `f_gnt`, `d_gnt`  out  1  request accepted this cycle (combinational).
- `f_rvalid`, `d_rvalid`  out  1  read data valid this cycle (registered).
- `rdata`  out  DATA_W  shared read data; equals `ram_data_out`.
- `ram_wr_en`  out  1  to RAM `wr_en`.
- `ram_address`  out  ADDR_W  to RAM `address`.
- `ram_data_in`  out  DATA_W  to RAM `data_in`.
- `ram_data_out`  in  DATA_W  from RAM `data_out` (registered in RAM, 1-cycle latency).

## Operation
State:
- `prio_q` (0 = F has priority, 1 = D has priority).
- `lock_q`.
- `f_rvalid_q`, `d_rvalid_q`.

Grant rules, evaluated each cycle:
- If `lock_q`=1: only D can be granted. `f_gnt`=0 regardless of `f_req`.
- Otherwise, if only one port requests, that port is granted.
- If both request, the port selected by `prio_q` is granted.
- At most one grant per cycle. No request means no grant, `ram_wr_en`=0, and address/data are driven from port F (don't-care).

Grant effects:
- The RAM interface is muxed combinationally from the granted port: `ram_wr_en` = granted port's `we`, plus its address and write data.
- `prio_q` updates on every grant, so the granted port becomes lowest priority (F granted → `prio_q`=1; D granted → `prio_q`=0).
- On a D grant, `lock_q` <= `d_lock`. Lock is released by a granted D access with `d_lock`=0. `d_lock` without `d_gnt` has no effect.
- A granted read sets that port's `rvalid_q`, so rvalid is asserted in the next cycle. A granted write produces no rvalid.
- `rdata` is a pass-through of `ram_data_out`. It is meaningful only while a `rvalid` is high.
- A RAM write leaves `ram_data_out` unchanged; consumers must not sample it without `rvalid`.

Reset (`rst`=1 at a rising edge):
- `prio_q`=0, `lock_q`=0, both `rvalid`=0.
- While `rst` is high, both `gnt`=0 and `ram_wr_en`=0, so no RAM access occurs.
- A read granted in the cycle before reset asserts produces no `rvalid`.

## Timing
- Grant: combinational, same cycle as req. The requester drops or changes req after the edge where `gnt`=1.
- Read latency: grant in cycle N → `rvalid` and valid `rdata` in cycle N+1.
- Write: RAM updated at the end of grant cycle N. A read of the same address granted in N+1 returns the new data in N+2.
- Throughput: one access per cycle. With both ports continuously requesting and unlocked, grants alternate F, D, F, D… starting from `prio_q`.
- Starvation bound: an unlocked requester waits at most 1 cycle. While locked, F waits until D releases; D is responsible for bounding the lock.
- Simultaneous read by one port and write by the other: only the winner proceeds; the loser holds req.

## Test plan
- Reset, then `f_req` read of addr 1023 (RAM preloaded 32'h766E2C96) → `f_gnt` in cycle 0, `f_rvalid`=1 with `rdata`=32'h766E2C96 in cycle 1, `d_rvalid`=0.
- D write addr 438 data 32'hDEADBEEF, then D read addr 438 next cycle → `ram_wr_en`=1 only in cycle 0, `d_rvalid` in cycle 2 with 32'hDEADBEEF.
- Both ports request reads continuously for 6 cycles after reset → grant sequence F,D,F,D,F,D; each `rvalid` one cycle after its grant.
- D read addr 8 with `d_lock`=1 while `f_req` held high, then D write addr 8 with `d_lock`=0 two cycles later → `f_gnt`=0 until the cycle after the unlocking D write, then F is granted.
- Assert `rst` in the cycle after an F read grant while D is locked → `f_rvalid`=0, `lock_q` cleared, next simultaneous request is granted to F.
- No requests for 5 cycles → `ram_wr_en`=0, both `gnt`=0, both `rvalid`=0, `prio_q` unchanged.
